// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-ported RAM between instruction fetch and
// data memory. The data port has priority. A starvation counter hands one
// grant to a waiting fetch after STARVE_MAX consecutive data grants. A wait
// counter aborts any grant that does not see ACCESS within TIMEOUT cycles.
//
// Ports:
//   CLK, RST                   clock (rising edge), synchronous active-high reset
//   iREN, iaddr                instruction read request/address (held until ihit)
//   ihit, iload                instruction completion pulse and data
//   dREN, dWEN, daddr, dstore  data request (write wins), address, write data
//   dhit, dload                data completion pulse and read data
//   ramREN, ramWEN, ramaddr,   RAM command side
//   ramstore
//   ramload, ramstate          RAM response (FREE/BUSY/ACCESS/ERROR)
//   timeout                    pulse when a grant is aborted by the wait limit
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout
);

  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;

  logic dreq, access, wait_last, starved;

  always_comb begin
    dreq      = dREN | dWEN;
    access    = (ramstate == ACCESS);
    wait_last = (wait_cnt == WW'(TIMEOUT - 1));
    starved   = iREN && (starve_cnt == SW'(STARVE_MAX));
  end

  // Outputs are decoded from the registered state; RST forces them low so a
  // reset that lands mid-transaction never produces a hit.
  always_comb begin
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    timeout  = 1'b0;
    if (!RST) begin
      case (state)
        DATA: begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          dhit    = access;
          dload   = access ? ramload : '0;
          timeout = !access && dreq && wait_last;
        end
        INST: begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          ihit    = access;
          iload   = access ? ramload : '0;
          timeout = !access && iREN && wait_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dreq && !starved) begin
            state    <= DATA;
            wait_cnt <= '0;
            if (!iREN)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + SW'(1);
          end else if (iREN) begin
            state      <= INST;
            wait_cnt   <= '0;
            starve_cnt <= '0;
          end
        end
        DATA: begin
          if (access || !dreq || wait_last)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt + WW'(1);
        end
        INST: begin
          if (access || !iREN || wait_last)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt + WW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  logic        use_addr_load;
  logic [31:0] load_val;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] K_I = 2'd0, K_D = 2'd1, K_T = 2'd2;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } evt_t;

  evt_t sb[$];

  // RAM model: either a fixed word or a word derived from the driven address.
  assign ramload = use_addr_load ? (ramaddr ^ 32'h5A5A_0000) : load_val;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic expect_evt(input logic [1:0] kind, input logic [31:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_evt(input logic [1:0] kind, input logic [31:0] data);
    evt_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: event kind %0d data %h with nothing expected", kind, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind != K_T && e.data != data)) begin
        errors++;
        $display("FAIL sb_event: got kind %0d data %h, expected kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a completion.
  always @(negedge CLK) begin
    checks++;
    if ((ihit && dhit) || (ramREN && ramWEN)) begin
      errors++;
      $display("FAIL exclusive: ihit=%b dhit=%b ramREN=%b ramWEN=%b, required no pair high",
               ihit, dhit, ramREN, ramWEN);
    end
    if (ihit)    check_evt(K_I, iload);
    if (dhit)    check_evt(K_D, dload);
    if (timeout) check_evt(K_T, 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h0; daddr = 32'h300; dstore = 32'h11;
    ramstate = S_ACCESS; use_addr_load = 1'b0; load_val = 32'hCAFE_0001;

    // 1. Reset with every request asserted
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_outs", 32'(|{ihit, dhit, ramREN, ramWEN, timeout, iload, dload, ramaddr, ramstore}), 32'h0);
    end
    RST = 1'b0;
    #1;
    chk("rst_release_idle", 32'(|{ihit, dhit, ramREN, ramWEN, timeout, ramaddr}), 32'h0);
    expect_evt(K_D, 32'hCAFE_0001);
    tick();
    chk("rst_first_grant_wen", 32'(ramWEN), 32'h1);
    chk("rst_first_grant_addr", ramaddr, 32'h300);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    tick();

    // 2. Single instruction read
    iREN = 1'b1; iaddr = 32'h40; load_val = 32'h8C01_0004;
    #1;
    chk("rd_c0_ramren", 32'(ramREN), 32'h0);
    expect_evt(K_I, 32'h8C01_0004);
    tick();
    chk("rd_c1_ihit", 32'(ihit), 32'h1);
    chk("rd_c1_iload", iload, 32'h8C01_0004);
    chk("rd_c1_addr", ramaddr, 32'h40);
    iREN = 1'b0;
    tick();
    chk("rd_c2_idle", 32'({ihit, ramREN}), 32'h0);

    // 3. Priority and starvation
    use_addr_load = 1'b1; daddr = 32'h200; iaddr = 32'h40;
    iREN = 1'b1; dREN = 1'b1;
    for (int k = 0; k < 4; k++) expect_evt(K_D, 32'h5A5A_0200);
    expect_evt(K_I, 32'h5A5A_0040);
    expect_evt(K_D, 32'h5A5A_0200);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("starve_ihit_c%0d", k), 32'(ihit), 32'(k == 9));
      chk($sformatf("starve_dhit_c%0d", k), 32'(dhit), 32'((k % 2 == 1) && (k != 9)));
    end
    tick();
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // 4. Write with wait states
    use_addr_load = 1'b0; load_val = 32'h0000_1234;
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    ramstate = S_BUSY;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        expect_evt(K_D, 32'h0000_1234);
        ramstate = S_ACCESS;
        #1;
      end
      chk($sformatf("wr_wen_c%0d", k), 32'({ramWEN, ramREN}), 32'h2);
      chk($sformatf("wr_addr_c%0d", k), ramaddr, 32'h100);
      chk($sformatf("wr_store_c%0d", k), ramstore, 32'hDEAD_BEEF);
      chk($sformatf("wr_dhit_c%0d", k), 32'(dhit), 32'(k == 4));
    end
    tick();
    dWEN = 1'b0; dREN = 1'b0; ramstate = S_FREE;
    tick();

    // 5. Timeout with ramstate stuck at ERROR
    dREN = 1'b1; daddr = 32'h180; ramstate = S_ERROR;
    expect_evt(K_T, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_timeout_c%0d", k), 32'(timeout), 32'(k == 8));
      chk($sformatf("to_ren_c%0d", k), 32'({ramREN, dhit}), 32'h2);
    end
    tick();
    chk("to_idle", 32'({ramREN, timeout}), 32'h0);
    tick();
    chk("to_regrant", 32'(ramREN), 32'h1);
    chk("to_regrant_addr", ramaddr, 32'h180);
    dREN = 1'b0;
    tick();
    ramstate = S_FREE;

    // 6. Silent abort, then pending fetch is granted
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h208; iaddr = 32'h44; ramstate = S_BUSY;
    tick();
    chk("ab_data_addr", ramaddr, 32'h208);
    chk("ab_data_ren", 32'(ramREN), 32'h1);
    dREN = 1'b0;
    #1;
    chk("ab_nohit", 32'({dhit, timeout}), 32'h0);
    tick();
    chk("ab_idle", 32'({ramREN, ramWEN, dhit, timeout}), 32'h0);
    tick();
    chk("ab_inst_addr", ramaddr, 32'h44);
    chk("ab_inst_wait", 32'({ramREN, ihit}), 32'h2);
    expect_evt(K_I, 32'h0000_0077);
    load_val = 32'h0000_0077; ramstate = S_ACCESS;
    #1;
    chk("ab_inst_ihit", 32'(ihit), 32'h1);
    tick();
    iREN = 1'b0; ramstate = S_FREE;
    #1;
    chk("ab_final_idle", 32'({ihit, ramREN}), 32'h0);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
